pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives write-enable and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, so ID/EX control fields are squashed on hazards.
- Detects load-use hazards, handles taken-branch flushes, and freezes the pipeline during multi-cycle data-memory accesses, with a watchdog timeout.
- Keeps saturating stall and flush performance counters.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the performance counters.
- TIMEOUT, 255, maximum MEM_WAIT cycles before entering ERR; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- ID_rs1_i  in  REG_AW  rs1 of the instruction in ID.
- ID_rs2_i  in  REG_AW  rs2 of the instruction in ID.
- ID_use_rs1_i  in  1  the ID instruction reads rs1.
- ID_use_rs2_i  in  1  the ID instruction reads rs2.
- EX_MemRead_i  in  1  the instruction in EX is a load.
- EX_rd_i  in  REG_AW  destination register of the instruction in EX.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mem_req_i  in  1  MEM stage accesses data memory this cycle.
- mem_ready_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID load enable.
- IFID_Flush_o  out  1  IF/ID clear to NOP.
- IDEX_Write_o  out  1  ID/EX load enable.
- IDEX_Bubble_o  out  1  ID/EX loads zero control fields.
- EXMEM_Write_o  out  1  EX/MEM load enable.
- MEMWB_Bubble_o  out  1  MEM/WB loads zero control fields.
- timeout_o  out  1  sticky watchdog error flag.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.
- flush_cnt_o  out  CNT_W  saturating count of flush cycles.

Behaviour:
- State is registered: RUN, MEM_WAIT, ERR. Control outputs are Mealy-decoded from state plus current inputs, so they take effect in the same cycle.
- Reset (rst_i low, asynchronous):
  - state=RUN, wait_cnt=0, timeout_o=0, stall_cnt_o=0, flush_cnt_o=0.
  - While rst_i is low: all *_Write_o and PCWrite_o =0, all flush/bubble outputs =0.
- Hazard definitions:
  - load_use = EX_MemRead_i & EX_rd_i!=0 & ((ID_use_rs1_i & ID_rs1_i==EX_rd_i) | (ID_use_rs2_i & ID_rs2_i==EX_rd_i)).
  - mem_busy = mem_req_i & !mem_ready_i.
- Default (no event): all Write outputs =1, all flush/bubble outputs =0.
- RUN, priority mem_busy > load_use > branch_taken_i:
  - mem_busy: freeze. PCWrite, IFID_Write, IDEX_Write, EXMEM_Write =0; MEMWB_Bubble=1. Next state MEM_WAIT, wait_cnt<=1.
  - load_use: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, EXMEM_Write=1. Stays in RUN; one-cycle bubble.
  - branch_taken_i (no load_use): IFID_Flush=1; PC loads the target.
  - load_use & branch_taken_i together: stall only, no flush. The branch re-resolves next cycle because the ID instruction is held.
- MEM_WAIT:
  - mem_ready_i=1: outputs revert to the RUN decode for current inputs (load_use/branch apply normally); next state RUN.
  - mem_ready_i=0: freeze as above; wait_cnt++.
  - TIMEOUT!=0 and wait_cnt==TIMEOUT with mem_ready_i=0: next state ERR.
  - branch_taken_i and load_use are ignored while frozen.
- ERR:
  - All Write outputs =0, bubble/flush =0, timeout_o=1.
  - Leaves ERR only on reset.
- Counters:
  - stall_cnt_o +1 on each cycle PCWrite_o=0 (excluding reset and ERR).
  - flush_cnt_o +1 on each cycle IFID_Flush_o=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; counters cleared.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, ERR}.
  - Default REG_AW/CNT_W/TIMEOUT constants.
  - Zero-control constant used for bubbles.
- One sub-module sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice for the stall and flush counters.

Test Plan:
- Load-use: EX_MemRead_i=1, EX_rd_i=5, ID_rs1_i=5, ID_use_rs1_i=1 -> same cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle (EX_MemRead_i=0) all clear; stall_cnt_o=1.
- rd=x0: EX_rd_i=0, ID_rs1_i=0, ID_use_rs1_i=1, EX_MemRead_i=1 -> no stall; stall_cnt_o stays 0.
- Branch with load-use: branch_taken_i=1 plus load-use -> IFID_Flush=0, stall only. Following cycle branch_taken_i=1 alone -> IFID_Flush=1; flush_cnt_o=1.
- Memory wait: mem_req_i=1, mem_ready_i=0 for 3 cycles, then ready -> freeze for 3 cycles (MEMWB_Bubble=1), release in the ready cycle, state RUN; stall_cnt_o=3.
- Watchdog: TIMEOUT=4, mem_ready_i held 0 -> ERR entered after the 5th frozen cycle, timeout_o=1 sticky. Assert rst_i=0 asynchronously -> timeout_o=0, counters 0, state RUN.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_cnt_o=15 and holds.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Default values for the parameters (register-address width, counter
//     width, watchdog limit).
//   - Controller state encoding.
//   - Packed bundle of the per-stage control outputs, plus the canonical
//     bundles for "all quiet", "normal run" and "full freeze".
//   - run_decode(): the RUN-state decode for load-use and taken-branch events.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  // Everything deasserted: used while in reset and in ERR.
  localparam ctrl_t CTRL_ZERO = '0;

  // Normal flow: every pipeline register loads, nothing squashed.
  localparam ctrl_t CTRL_DEFAULT = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
    idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};

  // Whole front end held while data memory is busy; MEM/WB receives a
  // bubble so the stalled MEM instruction does not write back twice.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
    idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};

  // Load-use wins over a taken branch: the branch stays in ID and is
  // resolved again on the following cycle, so no flush is issued here.
  function automatic ctrl_t run_decode(input logic load_use, input logic branch_taken);
    ctrl_t c;
    c = CTRL_DEFAULT;
    if (load_use) begin
      c.pc_write    = 1'b0;
      c.ifid_write  = 1'b0;
      c.idex_bubble = 1'b1;
    end else if (branch_taken) begin
      c.ifid_flush  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk_i : clock
//   rst_i : asynchronous active-low reset, clears the count
//   inc_i : increment request for this cycle
//   cnt_o : current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RISC-V pipeline.
//   Inputs : ID source registers and their use flags, EX load flag and rd,
//            branch-taken from ID, data-memory request/ready from MEM.
//   Outputs: write enables for PC, IF/ID, ID/EX, EX/MEM; IF/ID flush,
//            ID/EX bubble, MEM/WB bubble; sticky watchdog flag; saturating
//            stall and flush counters.
// Control outputs are Mealy: decoded from the registered state and the
// inputs of the current cycle.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ID_rs1_i,
  input  logic [REG_AW-1:0] ID_rs2_i,
  input  logic              ID_use_rs1_i,
  input  logic              ID_use_rs2_i,
  input  logic              EX_MemRead_i,
  input  logic [REG_AW-1:0] EX_rd_i,
  input  logic              branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              PCWrite_o,
  output logic              IFID_Write_o,
  output logic              IFID_Flush_o,
  output logic              IDEX_Write_o,
  output logic              IDEX_Bubble_o,
  output logic              EXMEM_Write_o,
  output logic              MEMWB_Bubble_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Wide enough to hold TIMEOUT; the counter never passes TIMEOUT when the
  // watchdog is enabled.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              r_state, w_state_next;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_next;
  logic                w_load_use, w_mem_busy;
  ctrl_t               w_ctrl, w_ctrl_out;
  logic [1:0]          w_cnt_inc;
  logic [CNT_W-1:0]    w_cnt [2];

  assign w_load_use = EX_MemRead_i && (EX_rd_i != '0) &&
                      ((ID_use_rs1_i && (ID_rs1_i == EX_rd_i)) ||
                       (ID_use_rs2_i && (ID_rs2_i == EX_rd_i)));
  assign w_mem_busy = mem_req_i && !mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_ctrl          = CTRL_ZERO;
    case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          w_ctrl          = CTRL_FREEZE;
          w_state_next    = MEM_WAIT;
          w_wait_cnt_next = WAIT_W'(1);
        end else begin
          w_ctrl = run_decode(w_load_use, branch_taken_i);
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          // Access completes: this cycle already behaves like RUN.
          w_ctrl          = run_decode(w_load_use, branch_taken_i);
          w_state_next    = RUN;
          w_wait_cnt_next = '0;
        end else begin
          // Hazards in ID are irrelevant while everything is frozen.
          w_ctrl = CTRL_FREEZE;
          if ((TIMEOUT != 0) && (r_wait_cnt == WAIT_W'(TIMEOUT))) begin
            w_state_next = ERR;
          end else if (r_wait_cnt != '1) begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
          end
        end
      end
      ERR: begin
        w_ctrl = CTRL_ZERO;
      end
      default: begin
        w_state_next    = RUN;
        w_wait_cnt_next = '0;
      end
    endcase
  end

  // Outputs are forced quiet for as long as reset is held, not just at the edge.
  assign w_ctrl_out = rst_i ? w_ctrl : CTRL_ZERO;

  assign PCWrite_o      = w_ctrl_out.pc_write;
  assign IFID_Write_o   = w_ctrl_out.ifid_write;
  assign IFID_Flush_o   = w_ctrl_out.ifid_flush;
  assign IDEX_Write_o   = w_ctrl_out.idex_write;
  assign IDEX_Bubble_o  = w_ctrl_out.idex_bubble;
  assign EXMEM_Write_o  = w_ctrl_out.exmem_write;
  assign MEMWB_Bubble_o = w_ctrl_out.memwb_bubble;
  assign timeout_o      = (r_state == ERR);

  // PCWrite is also low in ERR, but a dead pipeline is not counted as stalling.
  assign w_cnt_inc[0] = !w_ctrl_out.pc_write && (r_state != ERR);
  assign w_cnt_inc[1] = w_ctrl_out.ifid_flush;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (w_cnt_inc[gi]),
      .cnt_o (w_cnt[gi])
    );
  end

  assign stall_cnt_o = w_cnt[0];
  assign flush_cnt_o = w_cnt[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [REG_AW-1:0] ID_rs1_i = '0, ID_rs2_i = '0, EX_rd_i = '0;
  logic              ID_use_rs1_i = 1'b0, ID_use_rs2_i = 1'b0, EX_MemRead_i = 1'b0;
  logic              branch_taken_i = 1'b0, mem_req_i = 1'b0, mem_ready_i = 1'b0;
  logic              PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o;
  logic              IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o, timeout_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_use_rs1_i(ID_use_rs1_i), .ID_use_rs2_i(ID_use_rs2_i),
    .EX_MemRead_i(EX_MemRead_i), .EX_rd_i(EX_rd_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o), .IFID_Flush_o(IFID_Flush_o),
    .IDEX_Write_o(IDEX_Write_o), .IDEX_Bubble_o(IDEX_Bubble_o),
    .EXMEM_Write_o(EXMEM_Write_o), .MEMWB_Bubble_o(MEMWB_Bubble_o),
    .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "waiting" means the previous cycle was frozen on memory;
  // frozen_run counts consecutive frozen cycles for the watchdog.
  bit m_in_wait  = 1'b0;
  bit m_err      = 1'b0;
  int m_frozen_run = 0;
  int m_stalls   = 0;
  int m_flushes  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_ctrl();
    return {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o,
            IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o};
  endfunction

  task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit mrd, input int rd, input bit br, input bit req,
                        input bit rdy);
    ID_rs1_i = REG_AW'(rs1);  ID_rs2_i = REG_AW'(rs2);
    ID_use_rs1_i = u1;        ID_use_rs2_i = u2;
    EX_MemRead_i = mrd;       EX_rd_i = REG_AW'(rd);
    branch_taken_i = br;      mem_req_i = req;  mem_ready_i = rdy;
  endtask

  task automatic model_reset();
    m_in_wait = 1'b0; m_err = 1'b0; m_frozen_run = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Called with clock low and inputs applied; checks this cycle, then
  // advances the model and the clock to the next falling edge.
  task automatic step(input string tag);
    logic [6:0] exp;
    bit lu, frozen;
    #1;
    lu = EX_MemRead_i && (EX_rd_i != 0) &&
         ((ID_use_rs1_i && ID_rs1_i == EX_rd_i) || (ID_use_rs2_i && ID_rs2_i == EX_rd_i));
    frozen = !m_err && !mem_ready_i && (m_in_wait || mem_req_i);
    if (m_err)       exp = 7'b0000000;
    else if (frozen) exp = 7'b0000001;
    else             exp = {!lu, !lu, branch_taken_i && !lu, 1'b1, lu, 1'b1, 1'b0};
    check({tag, "_ctrl"}, 32'(dut_ctrl()), 32'(exp));
    check({tag, "_timeout"}, 32'(timeout_o), 32'(m_err));
    check({tag, "_stall_cnt"}, 32'(stall_cnt_o), 32'(m_stalls));
    check({tag, "_flush_cnt"}, 32'(flush_cnt_o), 32'(m_flushes));
    if (!m_err) begin
      if (!exp[6] && m_stalls < CNT_MAX) m_stalls++;
      if (exp[4] && m_flushes < CNT_MAX) m_flushes++;
      if (frozen) begin
        m_frozen_run++;
        if (TIMEOUT != 0 && m_frozen_run > TIMEOUT) m_err = 1'b1;
      end else begin
        m_frozen_run = 0;
      end
      m_in_wait = frozen;
    end
    @(negedge clk_i);
  endtask

  // Asserts reset asynchronously in the low phase of the clock and checks
  // that everything clears before any clock edge arrives.
  task automatic do_reset(input string tag);
    #2 rst_i = 1'b0;
    #1;
    check({tag, "_rst_ctrl"}, 32'(dut_ctrl()), 32'd0);
    check({tag, "_rst_timeout"}, 32'(timeout_o), 32'd0);
    check({tag, "_rst_stall"}, 32'(stall_cnt_o), 32'd0);
    check({tag, "_rst_flush"}, 32'(flush_cnt_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    @(negedge clk_i);
    check("por_ctrl", 32'(dut_ctrl()), 32'd0);
    check("por_stall", 32'(stall_cnt_o), 32'd0);
    check("por_flush", 32'(flush_cnt_o), 32'd0);
    check("por_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();

    // Load-use on rs1
    set_in(5, 0, 1, 0, 1, 5, 0, 0, 0); step("lu");
    set_in(5, 0, 1, 0, 0, 5, 0, 0, 0); step("lu_after");
    check("lu_stall_total", 32'(stall_cnt_o), 32'd1);

    // Load to x0 never stalls
    do_reset("x0");
    set_in(0, 0, 1, 0, 1, 0, 0, 0, 0); step("x0");
    check("x0_stall_total", 32'(stall_cnt_o), 32'd0);

    // Branch together with load-use: stall first, flush next cycle
    do_reset("brlu");
    set_in(5, 0, 1, 0, 1, 5, 1, 0, 0); step("brlu");
    set_in(5, 0, 1, 0, 0, 5, 1, 0, 0); step("br");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("br_after");
    check("br_flush_total", 32'(flush_cnt_o), 32'd1);
    check("br_stall_total", 32'(stall_cnt_o), 32'd1);

    // Three-cycle memory wait then release
    do_reset("mw");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); step("mw_busy");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); step("mw_ready");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mw_idle");
    check("mw_stall_total", 32'(stall_cnt_o), 32'd3);

    // Watchdog: ERR after the fifth frozen cycle, sticky until reset
    do_reset("wd");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("wd_wait");
    check("wd_not_yet", 32'(timeout_o), 32'd0);
    step("wd_last");
    check("wd_timeout", 32'(timeout_o), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("wd_err");
    check("wd_sticky", 32'(timeout_o), 32'd1);
    do_reset("wd_clear");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("wd_run");
    check("wd_run_pcwrite", 32'(PCWrite_o), 32'd1);

    // Stall counter saturation
    do_reset("sat");
    set_in(3, 7, 0, 1, 1, 7, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("sat");
    check("sat_stall_total", 32'(stall_cnt_o), 32'(CNT_MAX));

    // Randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      do_reset("rnd");
      for (int i = 0; i < 150; i++) begin
        set_in($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 99) < 50, $urandom_range(0, 3),
               $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 55);
        step("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
